// File: rtl/ppu_cpu_reg_port.sv
// CPU-facing PPU register file: control/scroll registers, the shared SCROLL/ADDR
// write toggle, and a held-request VRAM port for DATA reads and writes.
module ppu_cpu_reg_port (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_valid,
    output logic        busy,
    input  logic        vblank_in,
    output logic [7:0]  ppu_ctrl1,
    output logic [7:0]  ppu_ctrl2,
    output logic [15:0] cpu_scroll_addr,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re,
    input  logic [7:0]  vram_rdata,
    input  logic        vram_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ
    } state_t;

    state_t      r_state;
    logic        r_w;
    logic [5:0]  r_stage;
    logic [7:0]  r_rbuf;
    logic [13:0] r_addr;

    logic [13:0] w_inc;
    logic [13:0] w_addr_next;

    // The address is kept 14 bits wide so the +1/+32 step wraps at 0x4000 for free.
    assign w_inc       = ppu_ctrl1[0] ? 14'd32 : 14'd1;
    assign w_addr_next = r_addr + w_inc;
    assign vram_addr   = {2'b00, r_addr};
    assign busy        = (r_state != ST_IDLE);

    // NOTE: every register here is written with <= only; mixing in blocking
    // assignments would let later statements see same-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_w             <= 1'b0;
            r_stage         <= '0;
            r_rbuf          <= '0;
            r_addr          <= '0;
            ppu_ctrl1       <= '0;
            ppu_ctrl2       <= '0;
            cpu_scroll_addr <= '0;
            vram_wdata      <= '0;
            vram_we         <= 1'b0;
            vram_re         <= 1'b0;
            cpu_data_out    <= '0;
            cpu_data_valid  <= 1'b0;
        end else begin
            cpu_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A write wins over a simultaneous read; the read is simply dropped.
                    if (cpu_wr) begin
                        case (cpu_addr)
                            3'd0: ppu_ctrl1 <= cpu_data_in;
                            3'd1: ppu_ctrl2 <= cpu_data_in;
                            3'd5: begin
                                if (!r_w) cpu_scroll_addr[7:0]  <= cpu_data_in;
                                else      cpu_scroll_addr[15:8] <= cpu_data_in;
                                r_w <= ~r_w;
                            end
                            3'd6: begin
                                if (!r_w) r_stage <= cpu_data_in[5:0];
                                else      r_addr  <= {r_stage, cpu_data_in};
                                r_w <= ~r_w;
                            end
                            3'd7: begin
                                vram_wdata <= cpu_data_in;
                                vram_we    <= 1'b1;
                                r_state    <= ST_WR_REQ;
                            end
                            default: ;
                        endcase
                    end else if (cpu_rd) begin
                        cpu_data_valid <= 1'b1;
                        case (cpu_addr)
                            3'd2: begin
                                cpu_data_out <= {vblank_in, 7'b0};
                                r_w          <= 1'b0;
                            end
                            3'd7: begin
                                cpu_data_out <= r_rbuf;
                                vram_re      <= 1'b1;
                                r_state      <= ST_RD_REQ;
                            end
                            default: cpu_data_out <= 8'h00;
                        endcase
                    end
                end
                ST_WR_REQ: begin
                    if (vram_ack) begin
                        vram_we <= 1'b0;
                        r_addr  <= w_addr_next;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (vram_ack) begin
                        r_rbuf  <= vram_rdata;
                        vram_re <= 1'b0;
                        r_addr  <= w_addr_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_cpu_reg_port.sv
// Self-checking bench: a transaction-level model with a VRAM array is compared
// against every DUT output each cycle, under directed and random stimulus.
module tb_ppu_cpu_reg_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_valid;
    logic        busy;
    logic        vblank_in;
    logic [7:0]  ppu_ctrl1;
    logic [7:0]  ppu_ctrl2;
    logic [15:0] cpu_scroll_addr;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rdata;
    logic        vram_ack;

    ppu_cpu_reg_port dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_data_in    (cpu_data_in),
        .cpu_wr         (cpu_wr),
        .cpu_rd         (cpu_rd),
        .cpu_data_out   (cpu_data_out),
        .cpu_data_valid (cpu_data_valid),
        .busy           (busy),
        .vblank_in      (vblank_in),
        .ppu_ctrl1      (ppu_ctrl1),
        .ppu_ctrl2      (ppu_ctrl2),
        .cpu_scroll_addr(cpu_scroll_addr),
        .vram_addr      (vram_addr),
        .vram_wdata     (vram_wdata),
        .vram_we        (vram_we),
        .vram_re        (vram_re),
        .vram_rdata     (vram_rdata),
        .vram_ack       (vram_ack)
    );

    always #5 clk = ~clk;

    typedef enum {P_NONE, P_WRITE, P_READ} pend_t;

    pend_t       m_pend;
    logic [7:0]  m_ctrl1, m_ctrl2, m_wdata, m_dout, m_rbuf, m_stage;
    logic [15:0] m_scroll;
    int          m_addr;
    bit          m_w, m_valid;
    logic [7:0]  mem [0:16383];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic compare_all();
        check("ctrl1",  {8'h0, ppu_ctrl1},  {8'h0, m_ctrl1});
        check("ctrl2",  {8'h0, ppu_ctrl2},  {8'h0, m_ctrl2});
        check("scroll", cpu_scroll_addr,    m_scroll);
        check("vaddr",  vram_addr,          16'(m_addr));
        check("wdata",  {8'h0, vram_wdata}, {8'h0, m_wdata});
        check("we",     {15'h0, vram_we},   {15'h0, m_pend == P_WRITE});
        check("re",     {15'h0, vram_re},   {15'h0, m_pend == P_READ});
        check("busy",   {15'h0, busy},      {15'h0, m_pend != P_NONE});
        check("dout",   {8'h0, cpu_data_out}, {8'h0, m_dout});
        check("valid",  {15'h0, cpu_data_valid}, {15'h0, m_valid});
    endtask

    // One clock: present inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic wr, input logic rd,
                        input logic [2:0] a, input logic [7:0] d, input logic ack);
        rst         = r;
        cpu_wr      = wr;
        cpu_rd      = rd;
        cpu_addr    = a;
        cpu_data_in = d;
        vram_ack    = ack;
        vram_rdata  = mem[m_addr];
        @(posedge clk);
        if (r) begin
            m_pend = P_NONE; m_ctrl1 = 0; m_ctrl2 = 0; m_wdata = 0; m_dout = 0;
            m_rbuf = 0; m_stage = 0; m_scroll = 0; m_addr = 0; m_w = 0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (m_pend != P_NONE) begin
                if (ack) begin
                    if (m_pend == P_WRITE) mem[m_addr] = m_wdata;
                    else                   m_rbuf = mem[m_addr];
                    m_addr = (m_addr + (m_ctrl1[0] ? 32 : 1)) % 16384;
                    m_pend = P_NONE;
                end
            end else if (wr) begin
                case (a)
                    3'd0: m_ctrl1 = d;
                    3'd1: m_ctrl2 = d;
                    3'd5: begin
                        if (!m_w) m_scroll[7:0] = d; else m_scroll[15:8] = d;
                        m_w = !m_w;
                    end
                    3'd6: begin
                        if (!m_w) m_stage = d & 8'h3F; else m_addr = m_stage * 256 + d;
                        m_w = !m_w;
                    end
                    3'd7: begin m_wdata = d; m_pend = P_WRITE; end
                    default: ;
                endcase
            end else if (rd) begin
                m_valid = 1;
                case (a)
                    3'd2: begin m_dout = vblank_in ? 8'h80 : 8'h00; m_w = 0; end
                    3'd7: begin m_dout = m_rbuf; m_pend = P_READ; end
                    default: m_dout = 8'h00;
                endcase
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d); step(0, 1, 0, a, d, 0); endtask
    task automatic rd_reg(input logic [2:0] a); step(0, 0, 1, a, 8'h00, 0); endtask
    task automatic idle(); step(0, 0, 0, 3'd0, 8'h00, 0); endtask
    task automatic ack(); step(0, 0, 0, 3'd0, 8'h00, 1); endtask
    task automatic set_addr(input logic [15:0] v);
        rd_reg(3'd2);
        wr_reg(3'd6, v[15:8]);
        wr_reg(3'd6, v[7:0]);
    endtask

    initial begin
        vblank_in = 1'b0;
        m_addr    = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[16'h2000] = 8'h5A;

        step(1, 0, 0, 3'd0, 8'h00, 0);
        step(1, 0, 0, 3'd0, 8'h00, 0);
        check("rst_vaddr", vram_addr, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);

        // Scroll byte pair and STATUS clearing the toggle.
        wr_reg(3'd5, 8'h12);
        wr_reg(3'd5, 8'h34);
        check("scroll_pair", cpu_scroll_addr, 16'h3412);
        vblank_in = 1'b1;
        rd_reg(3'd2);
        check("status_val", {8'h0, cpu_data_out}, 16'h0080);
        check("status_vld", {15'h0, cpu_data_valid}, 16'h0001);
        vblank_in = 1'b0;
        wr_reg(3'd5, 8'h56);
        check("scroll_after_status", cpu_scroll_addr, 16'h3456);

        // Address load with high-bit masking, then a held write.
        rd_reg(3'd2);
        wr_reg(3'd6, 8'hFF);
        wr_reg(3'd6, 8'h20);
        check("addr_load", vram_addr, 16'h3F20);
        wr_reg(3'd7, 8'hAB);
        check("wr_we", {15'h0, vram_we}, 16'h0001);
        check("wr_wdata", {8'h0, vram_wdata}, 16'h00AB);
        idle();
        idle();
        check("wr_held", {15'h0, busy}, 16'h0001);
        ack();
        check("wr_inc", vram_addr, 16'h3F21);
        check("wr_done", {15'h0, busy}, 16'h0000);

        // Increment-32 stepping and modulo-0x4000 wrap.
        wr_reg(3'd0, 8'h01);
        set_addr(16'h23F0);
        wr_reg(3'd7, 8'h11);
        check("inc32_first", vram_addr, 16'h23F0);
        ack();
        check("inc32_second", vram_addr, 16'h2410);
        wr_reg(3'd7, 8'h22);
        ack();
        check("inc32_third", vram_addr, 16'h2430);
        set_addr(16'h3FF0);
        wr_reg(3'd7, 8'h33);
        ack();
        check("wrap32", vram_addr, 16'h0010);
        wr_reg(3'd0, 8'h00);
        set_addr(16'h3FFF);
        wr_reg(3'd7, 8'h44);
        ack();
        check("wrap1", vram_addr, 16'h0000);

        // Buffered DATA reads.
        set_addr(16'h2000);
        rd_reg(3'd7);
        check("rd_first", {8'h0, cpu_data_out}, 16'h0000);
        ack();
        rd_reg(3'd7);
        check("rd_second", {8'h0, cpu_data_out}, 16'h005A);
        ack();
        check("rd_addr", vram_addr, 16'h2002);
        ack();
        check("idle_ack", vram_addr, 16'h2002);

        // Busy lockout and write-over-read priority.
        wr_reg(3'd1, 8'h11);
        wr_reg(3'd7, 8'h55);
        wr_reg(3'd1, 8'h77);
        check("busy_ignore", {8'h0, ppu_ctrl2}, 16'h0011);
        ack();
        step(0, 1, 1, 3'd0, 8'h5C, 0);
        check("prio_wr", {8'h0, ppu_ctrl1}, 16'h005C);
        check("prio_novalid", {15'h0, cpu_data_valid}, 16'h0000);

        // Reset during an outstanding write with a coincident ack.
        set_addr(16'h1234);
        wr_reg(3'd7, 8'h66);
        step(1, 0, 0, 3'd0, 8'h00, 1);
        check("rst_mid_addr", vram_addr, 16'h0000);
        check("rst_mid_we", {15'h0, vram_we}, 16'h0000);
        check("rst_mid_busy", {15'h0, busy}, 16'h0000);
        idle();

        // Random traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            vblank_in = 1'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom), 8'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ppu_cpu_reg_port.md
PPU_CPU_REG_PORT -- requirements
Module: ppu_cpu_reg_port

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port cpu_addr, input, 3, register select: 0=CTRL1, 1=CTRL2, 2=STATUS, 5=SCROLL, 6=ADDR, 7=DATA; 3 and 4 are unused.
REQ-004 SHALL have port cpu_data_in, input, 8, CPU write data.
REQ-005 SHALL have port cpu_wr, input, 1, single-cycle write strobe.
REQ-006 SHALL have port cpu_rd, input, 1, single-cycle read strobe.
REQ-007 SHALL have port cpu_data_out, output, 8, registered read data.
REQ-008 SHALL have port cpu_data_valid, output, 1, one-cycle pulse qualifying cpu_data_out.
REQ-009 SHALL have port busy, output, 1, high while a VRAM transaction is outstanding.
REQ-010 SHALL have port vblank_in, input, 1, vblank flag reported through STATUS.
REQ-011 SHALL have port ppu_ctrl1, output, 8, CTRL1 register; bit1 is vertical nametable select, bit2 is horizontal nametable select, bit0 is increment mode.
REQ-012 SHALL have port ppu_ctrl2, output, 8, CTRL2 register.
REQ-013 SHALL have port cpu_scroll_addr, output, 16, scroll as {Y[15:8], X[7:0]}.
REQ-014 SHALL have port vram_addr, output, 16, VRAM address; bits 15:14 are always 0.
REQ-015 SHALL have port vram_wdata, output, 8, VRAM write data.
REQ-016 SHALL have port vram_we, output, 1, write request held until acknowledged.
REQ-017 SHALL have port vram_re, output, 1, read request held until acknowledged.
REQ-018 SHALL have port vram_rdata, input, 8, VRAM read data, valid when vram_ack is high.
REQ-019 SHALL have port vram_ack, input, 1, single-cycle completion of vram_we or vram_re.

Function
REQ-020 SHALL implement an FSM with states IDLE, WR_REQ, and RD_REQ; busy SHALL equal (state != IDLE).
REQ-021 SHALL ignore cpu_wr and cpu_rd entirely while busy: no register update, no toggle change, and no cpu_data_valid pulse.
REQ-022 SHALL give a write priority when cpu_wr and cpu_rd are high in the same cycle; the read is dropped and no valid pulse is produced.
REQ-023 SHALL load ppu_ctrl1 or ppu_ctrl2 from cpu_data_in on the edge following a write to address 0 or 1.
REQ-024 SHALL maintain a shared write toggle w for SCROLL and ADDR; w flips on every accepted write to address 5 or 6.
REQ-025 SHALL, on a SCROLL write, load cpu_scroll_addr[7:0] when w=0 and load cpu_scroll_addr[15:8] when w=1.
REQ-026 SHALL, on an ADDR write with w=0, latch {2'b00, cpu_data_in[5:0]} into a high-byte stage without changing vram_addr.
REQ-027 SHALL, on an ADDR write with w=1, set vram_addr to {stage, cpu_data_in} in a single edge.
REQ-028 SHALL, on a DATA write, set vram_wdata=cpu_data_in and enter WR_REQ with vram_we=1.
REQ-029 SHALL, in WR_REQ on vram_ack, deassert vram_we, increment vram_addr, and return to IDLE.
REQ-030 SHALL, on a DATA read, drive cpu_data_out with the read buffer's previous contents and pulse cpu_data_valid on the next cycle, and enter RD_REQ with vram_re=1.
REQ-031 SHALL, in RD_REQ on vram_ack, load the read buffer from vram_rdata, deassert vram_re, increment vram_addr, and return to IDLE.
REQ-032 SHALL use an increment of 32 when ppu_ctrl1[0]=1 and 1 otherwise; the increment value is sampled at the ack cycle.
REQ-033 SHALL perform vram_addr arithmetic modulo 0x4000, so 0x3FFF+1 yields 0x0000 and 0x3FF0+32 yields 0x0010.
REQ-034 SHALL, on a STATUS read, return {vblank_in, 7'b0} with a valid pulse next cycle and clear w.
REQ-035 SHALL return 0x00 with a valid pulse for reads of addresses 0, 1, 3, 4, 5, and 6.
REQ-036 SHALL discard writes to STATUS, address 3, and address 4.
REQ-037 SHALL never assert vram_we and vram_re simultaneously.
REQ-038 SHALL not time out a request: vram_we and vram_re stay high until vram_ack arrives.
REQ-039 SHALL ignore a vram_ack that arrives in IDLE.

Reset
REQ-040 SHALL, while rst is high, force state=IDLE, w=0, and the ADDR stage and read buffer to 0.
REQ-041 SHALL, while rst is high, force ppu_ctrl1, ppu_ctrl2, cpu_scroll_addr, vram_addr, vram_wdata, and cpu_data_out to 0.
REQ-042 SHALL, while rst is high, force vram_we, vram_re, cpu_data_valid, and busy to 0.
REQ-043 SHALL abandon any in-flight transaction on reset without incrementing vram_addr, and ignore a vram_ack arriving in the same cycle as rst.

Verification
REQ-044 SHALL be verified by: write 5←0x12, then 5←0x34 -> cpu_scroll_addr=0x3412; read 2 with vblank_in=1 -> 0x80; a further write 5←0x56 -> cpu_scroll_addr=0x3456.
REQ-045 SHALL be verified by: 6←0xFF, 6←0x20 -> vram_addr=0x3F20; 7←0xAB -> vram_we=1, vram_wdata=0xAB, busy=1; ack after 3 cycles -> vram_addr=0x3F21, busy=0.
REQ-046 SHALL be verified by: ctrl1←0x01, addr 0x23F0, two DATA writes -> addresses 0x23F0 then 0x2410; addr 0x3FFF with inc 1 -> 0x0000 after the write.
REQ-047 SHALL be verified by: addr 0x2000 containing 0x5A, then two DATA reads -> first returns 0x00, second returns 0x5A; vram_addr ends at 0x2002.
REQ-048 SHALL be verified by: a cpu_wr to 1 while busy -> ppu_ctrl2 unchanged; a simultaneous cpu_wr and cpu_rd to 0 -> write applied and no valid pulse.
REQ-049 SHALL be verified by: rst asserted in WR_REQ with vram_ack in the same cycle -> all outputs 0, state IDLE, no address increment.
